// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message front end.
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD80,
      PADZ,
      LEN,
      START,
      WAIT
   } state_t;

   localparam logic [7:0] PAD_BYTE        = 8'h80;
   localparam int         BLOCK_BYTES     = 64;
   localparam int         LEN_OFFSET      = 56;
   localparam int         WORDS_PER_BLOCK = 16;
   localparam int         WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/sha256_word_packer.sv
// Packs a byte stream big-endian into 32-bit words and writes them to the core W buffer.
module sha256_word_packer
   import sha256_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  word_we,
   output logic [3:0]            word_addr,
   output logic [31:0]           word_data,
   output logic [WORD_IDX_W+1:0] offset
);

   logic [23:0]           shift_q;
   logic [1:0]            byte_idx;
   logic [WORD_IDX_W-1:0] word_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         shift_q   <= '0;
         byte_idx  <= '0;
         word_idx  <= '0;
         word_we   <= 1'b0;
         word_addr <= '0;
         word_data <= '0;
      end else begin
         word_we <= 1'b0;
         if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            shift_q  <= {shift_q[15:0], byte_data};
            if (byte_idx == 2'd3) begin
               word_we   <= 1'b1;
               word_addr <= word_idx;
               word_data <= {shift_q, byte_data};
               word_idx  <= word_idx + 1'b1;
            end
         end
      end
   end

   // Byte position of the next byte within the current 64-byte block.
   assign offset = {word_idx, byte_idx};

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Message front end for the SHA-256 core: byte intake, padding, and block handshake.
//
// state | meaning
// IDLE  | no message in flight, waiting for first byte or empty-message complete
// LOAD  | accepting message bytes
// PAD80 | emitting the 0x80 terminator byte
// PADZ  | emitting zero fill (up to the length field, or to end of block)
// LEN   | emitting the 64-bit bit length, MSB first
// START | last word of the block is being written; raise block_start next
// WAIT  | core compressing, waiting for block_done
module sha256_msg_sequencer
   import sha256_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_enable,
   input  logic [7:0]  input_data,
   input  logic        input_complete,
   output logic        ready,
   output logic        word_we,
   output logic [3:0]  word_addr,
   output logic [31:0] word_data,
   output logic        block_start,
   output logic        first_block,
   input  logic        block_done,
   output logic        msg_done,
   output logic        busy
);

   localparam logic [5:0] OFF_LAST   = 6'(BLOCK_BYTES - 1);
   localparam logic [5:0] OFF_PRELEN = 6'(LEN_OFFSET - 1);

   state_t             state;
   logic [COUNT_W-1:0] byte_count;
   logic [COUNT_W-1:0] blk_idx;
   logic               comp_seen;
   logic               pad_fill;
   logic               pad_pending;
   logic               last_blk;
   logic               accept;
   logic               pk_valid;
   logic [7:0]         pk_data;
   logic [5:0]         offset;
   logic [63:0]        len_bits;
   logic [63:0]        len_shift;

   assign accept    = load_enable && ready;
   assign len_bits  = 64'(byte_count) << 3;
   // Offset 56..63 selects length byte 7..0 (MSB first).
   assign len_shift = len_bits >> {~offset[2:0], 3'b000};

   always_comb begin
      pk_valid = accept;
      pk_data  = input_data;
      case (state)
         PAD80: begin pk_valid = 1'b1; pk_data = PAD_BYTE;       end
         PADZ:  begin pk_valid = 1'b1; pk_data = 8'h00;          end
         LEN:   begin pk_valid = 1'b1; pk_data = len_shift[7:0]; end
         default: ;
      endcase
   end

   sha256_word_packer u_packer (
      .clock      (clock),
      .reset      (reset),
      .byte_valid (pk_valid),
      .byte_data  (pk_data),
      .word_we    (word_we),
      .word_addr  (word_addr),
      .word_data  (word_data),
      .offset     (offset)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ready       <= 1'b0;
         block_start <= 1'b0;
         first_block <= 1'b0;
         msg_done    <= 1'b0;
         busy        <= 1'b0;
         byte_count  <= '0;
         blk_idx     <= '0;
         comp_seen   <= 1'b0;
         pad_fill    <= 1'b0;
         pad_pending <= 1'b0;
         last_blk    <= 1'b0;
      end else begin
         ready       <= 1'b0;
         block_start <= 1'b0;
         first_block <= 1'b0;
         msg_done    <= 1'b0;
         busy        <= 1'b1;
         if (accept) byte_count <= byte_count + COUNT_W'(1);
         case (state)
            IDLE, LOAD: begin
               if (accept && offset == OFF_LAST) begin
                  state     <= START;
                  comp_seen <= input_complete;
               end else if (input_complete) begin
                  state <= PAD80;
               end else begin
                  ready <= 1'b1;
                  busy  <= (state == LOAD) || accept;
                  if (accept) state <= LOAD;
               end
            end
            PAD80: begin
               if (offset == OFF_PRELEN) begin
                  state <= LEN;
               end else if (offset == OFF_LAST) begin
                  state       <= START;
                  pad_pending <= 1'b1;
               end else begin
                  state    <= PADZ;
                  pad_fill <= (offset > OFF_PRELEN);
               end
            end
            PADZ: begin
               // No room for the length field: zero-fill this block, length goes in the next.
               if (pad_fill) begin
                  if (offset == OFF_LAST) begin
                     state       <= START;
                     pad_pending <= 1'b1;
                     pad_fill    <= 1'b0;
                  end
               end else if (offset == OFF_PRELEN) begin
                  state <= LEN;
               end
            end
            LEN: begin
               if (offset == OFF_LAST) begin
                  state    <= START;
                  last_blk <= 1'b1;
               end
            end
            START: begin
               block_start <= 1'b1;
               first_block <= (blk_idx == '0);
               state       <= WAIT;
            end
            WAIT: begin
               if (block_done) begin
                  blk_idx <= blk_idx + COUNT_W'(1);
                  if (last_blk) begin
                     msg_done   <= 1'b1;
                     state      <= IDLE;
                     ready      <= 1'b1;
                     busy       <= 1'b0;
                     byte_count <= '0;
                     blk_idx    <= '0;
                     last_blk   <= 1'b0;
                  end else if (pad_pending) begin
                     state       <= PADZ;
                     pad_pending <= 1'b0;
                  end else if (comp_seen) begin
                     state     <= PAD80;
                     comp_seen <= 1'b0;
                  end else begin
                     state <= LOAD;
                     ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench: captures each block written to the W buffer and compares against hand-computed words.
module tb_sha256_msg_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        load_enable = 1'b0;
   logic [7:0]  input_data = 8'h00;
   logic        input_complete = 1'b0;
   logic        block_done = 1'b0;
   logic        ready;
   logic        word_we;
   logic [3:0]  word_addr;
   logic [31:0] word_data;
   logic        block_start;
   logic        first_block;
   logic        msg_done;
   logic        busy;

   always #5 clock = ~clock;

   sha256_msg_sequencer #(.COUNT_W(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .load_enable    (load_enable),
      .input_data     (input_data),
      .input_complete (input_complete),
      .ready          (ready),
      .word_we        (word_we),
      .word_addr      (word_addr),
      .word_data      (word_data),
      .block_start    (block_start),
      .first_block    (first_block),
      .block_done     (block_done),
      .msg_done       (msg_done),
      .busy           (busy)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] wbuf [16] = '{default: 32'hdeadbeef};
   logic [31:0] cap [32][16];
   logic        cap_first [32];
   int          nblk = 0;
   int          nmsg = 0;

   // Core-side model: W buffer plus a snapshot per block_start.
   always @(negedge clock) begin
      if (word_we) wbuf[word_addr] = word_data;
      if (block_start) begin
         if (nblk < 32) begin
            for (int i = 0; i < 16; i++) cap[nblk][i] = wbuf[i];
            cap_first[nblk] = first_block;
         end
         for (int i = 0; i < 16; i++) wbuf[i] = 32'hdeadbeef;
         nblk++;
      end
      if (msg_done) nmsg++;
   end

   typedef struct {
      int          tid;
      int          blk;
      int          lo;
      int          hi;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [7:0]  msg_q[$];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check_words(input int tid, input int base);
      foreach (vecs[k]) begin
         if (vecs[k].tid == tid) begin
            logic [31:0] act;
            int          bi;
            act = vecs[k].exp;
            bi  = base + vecs[k].blk;
            if (bi > 31) bi = 31;
            for (int a = vecs[k].lo; a <= vecs[k].hi; a++) begin
               if (cap[bi][a] !== vecs[k].exp) begin
                  act = cap[bi][a];
                  break;
               end
            end
            chk32($sformatf("t%0d_b%0d_w%0d_%0d", tid, vecs[k].blk, vecs[k].lo, vecs[k].hi),
                  act, vecs[k].exp);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic comp);
      int t;
      t = 0;
      while (!ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (!ready) chk1("send_ready_timeout", ready, 1'b1);
      load_enable    = 1'b1;
      input_data     = b;
      input_complete = comp;
      @(negedge clock);
      load_enable    = 1'b0;
      input_complete = 1'b0;
   endtask

   task automatic pulse_complete();
      input_complete = 1'b1;
      @(negedge clock);
      input_complete = 1'b0;
   endtask

   task automatic serve_blocks(input int n, input bit stray);
      for (int b = 0; b < n; b++) begin
         int t;
         t = 0;
         while (!block_start && t < 300) begin
            @(negedge clock);
            t++;
         end
         if (!block_start) begin
            chk1("block_start_timeout", block_start, 1'b1);
            return;
         end
         chk1("ready_low_at_start", ready, 1'b0);
         repeat (3) begin
            @(negedge clock);
            chk1("ready_low_wait", ready, 1'b0);
            if (stray) begin
               load_enable    = 1'b1;
               input_data     = 8'hff;
               input_complete = 1'b1;
            end
         end
         load_enable    = 1'b0;
         input_complete = 1'b0;
         block_done = 1'b1;
         @(negedge clock);
         block_done = 1'b0;
         chk1($sformatf("msg_done_b%0d", b), msg_done, b == n - 1);
      end
   endtask

   task automatic run_msg(input int tid, input bit comp_last, input bit stray, input int exp_blocks);
      int base_blk;
      int base_msg;
      base_blk = nblk;
      base_msg = nmsg;
      for (int i = 0; i < msg_q.size(); i++) begin
         send_byte(msg_q[i], comp_last && (i == msg_q.size() - 1));
         if (stray && i == 3) begin
            block_done = 1'b1;
            @(negedge clock);
            block_done = 1'b0;
            chk1("stray_done_ready", ready, 1'b1);
            chk1("stray_done_busy", busy, 1'b1);
            chk1("stray_done_no_start", block_start, 1'b0);
         end
      end
      if (!comp_last || msg_q.size() == 0) pulse_complete();
      serve_blocks(exp_blocks, stray);
      @(negedge clock);
      chk32($sformatf("t%0d_nblk", tid), nblk - base_blk, exp_blocks);
      chk32($sformatf("t%0d_nmsg", tid), nmsg - base_msg, 1);
      chk1($sformatf("t%0d_first0", tid), cap_first[base_blk], 1'b1);
      if (exp_blocks > 1) chk1($sformatf("t%0d_first1", tid), cap_first[base_blk + 1], 1'b0);
      chk1($sformatf("t%0d_idle_ready", tid), ready, 1'b1);
      chk1($sformatf("t%0d_idle_busy", tid), busy, 1'b0);
      check_words(tid, base_blk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_ready"}, ready, 1'b0);
      chk1({tag, "_word_we"}, word_we, 1'b0);
      chk32({tag, "_word_addr"}, 32'(word_addr), 32'd0);
      chk32({tag, "_word_data"}, word_data, 32'd0);
      chk1({tag, "_block_start"}, block_start, 1'b0);
      chk1({tag, "_first_block"}, first_block, 1'b0);
      chk1({tag, "_msg_done"}, msg_done, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic load_goirish();
      msg_q = '{8'h67, 8'h6f, 8'h69, 8'h72, 8'h69, 8'h73, 8'h68, 8'h0a};
   endtask

   initial begin
      int base_msg;

      vecs.push_back('{0, 0, 0, 0, 32'h676f6972});
      vecs.push_back('{0, 0, 1, 1, 32'h6973680a});
      vecs.push_back('{0, 0, 2, 2, 32'h80000000});
      vecs.push_back('{0, 0, 3, 14, 32'h00000000});
      vecs.push_back('{0, 0, 15, 15, 32'h00000040});
      vecs.push_back('{1, 0, 0, 0, 32'h80000000});
      vecs.push_back('{1, 0, 1, 15, 32'h00000000});
      vecs.push_back('{2, 0, 0, 13, 32'h61616161});
      vecs.push_back('{2, 0, 14, 14, 32'h80000000});
      vecs.push_back('{2, 0, 15, 15, 32'h00000000});
      vecs.push_back('{2, 1, 0, 14, 32'h00000000});
      vecs.push_back('{2, 1, 15, 15, 32'h000001c0});
      vecs.push_back('{3, 0, 0, 0, 32'h00010203});
      vecs.push_back('{3, 0, 15, 15, 32'h3c3d3e3f});
      vecs.push_back('{3, 1, 0, 0, 32'h80000000});
      vecs.push_back('{3, 1, 1, 14, 32'h00000000});
      vecs.push_back('{3, 1, 15, 15, 32'h00000200});
      vecs.push_back('{4, 0, 0, 12, 32'h62626262});
      vecs.push_back('{4, 0, 13, 13, 32'h62626280});
      vecs.push_back('{4, 0, 14, 14, 32'h00000000});
      vecs.push_back('{4, 0, 15, 15, 32'h000001b8});
      vecs.push_back('{5, 0, 0, 0, 32'h61626380});
      vecs.push_back('{5, 0, 1, 14, 32'h00000000});
      vecs.push_back('{5, 0, 15, 15, 32'h00000018});
      vecs.push_back('{6, 0, 0, 0, 32'h676f6972});
      vecs.push_back('{6, 0, 1, 1, 32'h6973680a});
      vecs.push_back('{6, 0, 2, 2, 32'h80000000});
      vecs.push_back('{6, 0, 3, 14, 32'h00000000});
      vecs.push_back('{6, 0, 15, 15, 32'h00000040});

      repeat (2) @(negedge clock);
      check_reset_outputs("por");
      reset = 1'b0;
      @(negedge clock);
      chk1("por_ready_after", ready, 1'b1);

      load_goirish();
      run_msg(0, 1'b0, 1'b0, 1);

      msg_q.delete();
      run_msg(1, 1'b0, 1'b0, 1);

      msg_q.delete();
      repeat (56) msg_q.push_back(8'h61);
      run_msg(2, 1'b1, 1'b0, 2);

      msg_q.delete();
      for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
      run_msg(3, 1'b1, 1'b0, 2);

      msg_q.delete();
      repeat (55) msg_q.push_back(8'h62);
      run_msg(4, 1'b0, 1'b0, 1);

      // Abandon a message while the core is busy with its block.
      base_msg = nmsg;
      msg_q = '{8'h61, 8'h62, 8'h63};
      for (int i = 0; i < 3; i++) send_byte(msg_q[i], i == 2);
      begin
         int t;
         t = 0;
         while (!block_start && t < 300) begin
            @(negedge clock);
            t++;
         end
         chk1("abort_block_start", block_start, 1'b1);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("wait_rst");
      reset = 1'b0;
      @(negedge clock);
      chk1("wait_rst_ready_after", ready, 1'b1);
      block_done = 1'b1;
      @(negedge clock);
      block_done = 1'b0;
      repeat (4) @(negedge clock);
      chk32("wait_rst_no_msg_done", nmsg - base_msg, 0);
      chk1("wait_rst_idle_busy", busy, 1'b0);
      run_msg(5, 1'b1, 1'b0, 1);

      load_goirish();
      run_msg(6, 1'b0, 1'b1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
